// File: rtl/riscv_fetch.sv
// Instruction fetch unit: owns the PC, drives the ROM address and queues fetched words toward decode.
// Optional macro RISCV_FETCH_PERF_EN adds perf_fetch_cnt_o, a 64-bit count of successful fetches.
module riscv_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [63:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        imem_misaligned_i,
    input  logic        imem_invalid_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [63:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        fault_o,
    output logic [63:0] fault_pc_o,
    output logic [1:0]  fault_cause_o
`ifdef RISCV_FETCH_PERF_EN
    ,
    output logic [63:0] perf_fetch_cnt_o
`endif
);

    localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_pc;
    logic [63:0] w_pc_nxt;
    logic [1:0]  r_count;
    logic [1:0]  w_count_nxt;
    logic [1:0]  w_wr_idx;
    logic        r_valid;
    logic        w_pop;
    logic        w_space;
    logic        w_err;
    logic        w_push;
    logic        w_fault_set;

    // slot 0 is always the head, so the head outputs come straight from flops
    logic [31:0] r_s0_instr;
    logic [63:0] r_s0_pc;
    logic [31:0] r_s1_instr;
    logic [63:0] r_s1_pc;
    logic [31:0] w_s0_instr_nxt;
    logic [63:0] w_s0_pc_nxt;
    logic [31:0] w_s1_instr_nxt;
    logic [63:0] w_s1_pc_nxt;

    logic        r_fault;
    logic [63:0] r_fault_pc;
    logic [1:0]  r_fault_cause;

`ifdef RISCV_FETCH_PERF_EN
    logic [63:0] r_perf_cnt;
`endif

    // FSM next state and fetch decision
    always_comb begin
        w_pop       = r_valid & instr_ready_i;
        w_space     = (r_count < FULL_CNT) | w_pop;
        w_err       = imem_misaligned_i | imem_invalid_i;
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_fault_set = 1'b0;
        if (redirect_i) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    // an error while stalled is only acted on once space frees
                    if (w_space && w_err) begin
                        w_state_nxt = ST_FAULT;
                        w_fault_set = 1'b1;
                    end else if (w_space) begin
                        w_push = 1'b1;
                    end else begin
                        w_push = 1'b0;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_BOOT;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // queue shift/write and PC next value
    always_comb begin
        w_s0_instr_nxt = r_s0_instr;
        w_s0_pc_nxt    = r_s0_pc;
        w_s1_instr_nxt = r_s1_instr;
        w_s1_pc_nxt    = r_s1_pc;
        w_pc_nxt       = r_pc;
        w_count_nxt    = r_count;
        w_wr_idx       = r_count - {1'b0, w_pop};
        if (redirect_i) begin
            w_count_nxt = 2'd0;
            w_pc_nxt    = redirect_pc_i;
        end else begin
            w_s0_instr_nxt = w_pop ? r_s1_instr : r_s0_instr;
            w_s0_pc_nxt    = w_pop ? r_s1_pc : r_s0_pc;
            if (w_push) begin
                if (w_wr_idx == 2'd0) begin
                    w_s0_instr_nxt = imem_instr_i;
                    w_s0_pc_nxt    = r_pc;
                end else begin
                    w_s1_instr_nxt = imem_instr_i;
                    w_s1_pc_nxt    = r_pc;
                end
                w_pc_nxt = r_pc + 64'd4;
            end else begin
                w_pc_nxt = r_pc;
            end
            w_count_nxt = r_count - {1'b0, w_pop} + {1'b0, w_push};
        end
    end

    // PC, queue storage and head-valid registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc       <= RESET_PC;
            r_count    <= 2'd0;
            r_valid    <= 1'b0;
            r_s0_instr <= 32'd0;
            r_s0_pc    <= 64'd0;
            r_s1_instr <= 32'd0;
            r_s1_pc    <= 64'd0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_count    <= w_count_nxt;
            r_valid    <= (w_count_nxt != 2'd0);
            r_s0_instr <= w_s0_instr_nxt;
            r_s0_pc    <= w_s0_pc_nxt;
            r_s1_instr <= w_s1_instr_nxt;
            r_s1_pc    <= w_s1_pc_nxt;
        end
    end

    // sticky fault record, cleared only by redirect or reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fault       <= 1'b0;
            r_fault_pc    <= 64'd0;
            r_fault_cause <= 2'd0;
        end else if (redirect_i) begin
            r_fault       <= 1'b0;
            r_fault_pc    <= 64'd0;
            r_fault_cause <= 2'd0;
        end else if (w_fault_set) begin
            r_fault       <= 1'b1;
            r_fault_pc    <= r_pc;
            r_fault_cause <= {imem_invalid_i, imem_misaligned_i};
        end else begin
            r_fault       <= r_fault;
            r_fault_pc    <= r_fault_pc;
            r_fault_cause <= r_fault_cause;
        end
    end

`ifdef RISCV_FETCH_PERF_EN
    // successful-fetch counter, survives redirects
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_cnt <= 64'd0;
        end else if (w_push) begin
            r_perf_cnt <= r_perf_cnt + 64'd1;
        end else begin
            r_perf_cnt <= r_perf_cnt;
        end
    end

    assign perf_fetch_cnt_o = r_perf_cnt;
`endif

    assign imem_addr_o   = r_pc;
    assign instr_valid_o = r_valid;
    assign instr_o       = r_s0_instr;
    assign instr_pc_o    = r_s0_pc;
    assign fault_o       = r_fault;
    assign fault_pc_o    = r_fault_pc;
    assign fault_cause_o = r_fault_cause;

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: a cycle table from reset plus hand sequences for fault and async reset.
module tb_riscv_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_mis;
    logic        imem_inv;
    logic        ivalid;
    logic [31:0] instr;
    logic [63:0] ipc;
    logic        ready = 1'b1;
    logic        rdr = 1'b0;
    logic [63:0] rdr_pc = 64'd0;
    logic        fault;
    logic [63:0] fpc;
    logic [1:0]  fcause;
`ifdef RISCV_FETCH_PERF_EN
    logic [63:0] perf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_fetch dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .imem_addr_o       (imem_addr),
        .imem_instr_i      (imem_instr),
        .imem_misaligned_i (imem_mis),
        .imem_invalid_i    (imem_inv),
        .instr_valid_o     (ivalid),
        .instr_o           (instr),
        .instr_pc_o        (ipc),
        .instr_ready_i     (ready),
        .redirect_i        (rdr),
        .redirect_pc_i     (rdr_pc),
        .fault_o           (fault),
        .fault_pc_o        (fpc),
        .fault_cause_o     (fcause)
`ifdef RISCV_FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o  (perf)
`endif
    );

    // ROM model: valid below 0x400 and in the top 256 bytes of the address space
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h1300_0013 ^ a[31:0];
    endfunction

    always_comb begin
        imem_instr = mem_word(imem_addr);
        imem_mis   = (imem_addr[1:0] != 2'b00);
        imem_inv   = (imem_addr >= 64'h400) && (imem_addr < 64'hFFFF_FFFF_FFFF_FF00);
    end

    typedef struct {
        logic        rdr;
        logic [63:0] rpc;
        logic        rdy;
        logic        ev;
        logic [63:0] eipc;
        logic [63:0] eaddr;
        logic        ef;
        logic [63:0] efpc;
        logic [1:0]  ec;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic r, input logic [63:0] rp, input logic rd, input logic ev,
                       input logic [63:0] eipc, input logic [63:0] eaddr, input logic ef,
                       input logic [63:0] efpc, input logic [1:0] ec);
        vec_t v;
        v.rdr = r; v.rpc = rp; v.rdy = rd; v.ev = ev; v.eipc = eipc;
        v.eaddr = eaddr; v.ef = ef; v.efpc = efpc; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " valid"}, {63'd0, ivalid}, 64'd0);
        chk({tag, " instr"}, {32'd0, instr}, 64'd0);
        chk({tag, " ipc"}, ipc, 64'd0);
        chk({tag, " addr"}, imem_addr, 64'd0);
        chk({tag, " fault"}, {63'd0, fault}, 64'd0);
        chk({tag, " fpc"}, fpc, 64'd0);
        chk({tag, " cause"}, {62'd0, fcause}, 64'd0);
`ifdef RISCV_FETCH_PERF_EN
        chk({tag, " perf"}, perf, 64'd0);
`endif
    endtask

    initial begin
        // rdr rpc rdy | valid ipc addr fault fpc cause
        add(0, 0, 1,  0, 0, 64'h0,  0, 0, 0);      // BOOT -> RUN
        add(0, 0, 1,  1, 0, 64'h4,  0, 0, 0);      // first word visible
        add(0, 0, 1,  1, 4, 64'h8,  0, 0, 0);
        add(0, 0, 1,  1, 8, 64'hC,  0, 0, 0);
        add(0, 0, 1,  1, 64'hC, 64'h10, 0, 0, 0);
        add(1, 0, 1,  0, 0, 64'h0,  0, 0, 0);      // restart at 0 for backpressure
        add(0, 0, 0,  1, 0, 64'h4,  0, 0, 0);
        add(0, 0, 0,  1, 0, 64'h8,  0, 0, 0);
        add(0, 0, 0,  1, 0, 64'h8,  0, 0, 0);      // full, stalled
        add(0, 0, 0,  1, 0, 64'h8,  0, 0, 0);
        add(0, 0, 0,  1, 0, 64'h8,  0, 0, 0);
        add(0, 0, 1,  1, 4, 64'hC,  0, 0, 0);      // push+pop while full
        add(0, 0, 1,  1, 8, 64'h10, 0, 0, 0);
        add(1, 0, 1,  0, 0, 64'h0,  0, 0, 0);
        add(0, 0, 0,  1, 0, 64'h4,  0, 0, 0);
        add(0, 0, 0,  1, 0, 64'h8,  0, 0, 0);
        add(1, 64'h100, 0,  0, 0, 64'h100, 0, 0, 0); // redirect while full
        add(0, 0, 1,  1, 64'h100, 64'h104, 0, 0, 0);
        add(1, 64'h3F8, 0,  0, 0, 64'h3F8, 0, 0, 0);
        add(0, 0, 0,  1, 64'h3F8, 64'h3FC, 0, 0, 0);
        add(0, 0, 0,  1, 64'h3F8, 64'h400, 0, 0, 0);
        add(0, 0, 0,  1, 64'h3F8, 64'h400, 0, 0, 0); // invalid ignored while full
        add(0, 0, 1,  1, 64'h3FC, 64'h400, 1, 64'h400, 2'b10);
        add(0, 0, 1,  0, 0, 64'h400, 1, 64'h400, 2'b10);
        add(0, 0, 1,  0, 0, 64'h400, 1, 64'h400, 2'b10);
        add(1, 64'h2, 1,  0, 0, 64'h2, 0, 0, 0);   // recovery clears fault
        add(0, 0, 1,  0, 0, 64'h2, 1, 64'h2, 2'b01);
        add(1, 0, 1,  0, 0, 64'h0, 0, 0, 0);
        add(0, 0, 1,  1, 0, 64'h4, 0, 0, 0);
        add(0, 0, 1,  1, 4, 64'h8, 0, 0, 0);
        add(1, 64'hFFFF_FFFF_FFFF_FFFC, 1,  0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
        add(0, 0, 1,  1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, 0, 0); // PC wraps
        add(0, 0, 1,  1, 0, 64'h4, 0, 0, 0);

        #1 rst = 1'b1;
        #1 chk_reset_vals("reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            rdr    = vecs[i].rdr;
            rdr_pc = vecs[i].rpc;
            ready  = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("r%0d valid", i + 1), {63'd0, ivalid}, {63'd0, vecs[i].ev});
            if (vecs[i].ev) begin
                chk($sformatf("r%0d ipc", i + 1), ipc, vecs[i].eipc);
                chk($sformatf("r%0d instr", i + 1), {32'd0, instr}, {32'd0, mem_word(vecs[i].eipc)});
            end
            chk($sformatf("r%0d addr", i + 1), imem_addr, vecs[i].eaddr);
            chk($sformatf("r%0d fault", i + 1), {63'd0, fault}, {63'd0, vecs[i].ef});
            chk($sformatf("r%0d fpc", i + 1), fpc, vecs[i].efpc);
            chk($sformatf("r%0d cause", i + 1), {62'd0, fcause}, {62'd0, vecs[i].ec});
        end
`ifdef RISCV_FETCH_PERF_EN
        chk("perf after table", perf, 64'd17);
`endif

        // fault with an entry still queued, then async reset between edges
        rdr = 1'b1; rdr_pc = 64'h3FC; ready = 1'b0;
        @(posedge clk); #1;
        rdr = 1'b0;
        chk("seq addr 3fc", imem_addr, 64'h3FC);
        @(posedge clk); #1;
        chk("seq head 3fc", ipc, 64'h3FC);
        @(posedge clk); #1;
        chk("seq fault set", {63'd0, fault}, 64'd1);
        chk("seq fault pc", fpc, 64'h400);
        chk("seq fault valid", {63'd0, ivalid}, 64'd1);
        #3 rst = 1'b1;
        #1 chk_reset_vals("async rst");
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        @(posedge clk); #1;
        chk("post rst boot valid", {63'd0, ivalid}, 64'd0);
        @(posedge clk); #1;
        chk("post rst valid", {63'd0, ivalid}, 64'd1);
        chk("post rst ipc", ipc, 64'd0);
        chk("post rst addr", imem_addr, 64'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
